// File: rtl/display_pkg.sv
// display_pkg: segment patterns and display geometry shared by the 7-segment display stage.
package display_pkg;
  localparam int DIGITS = 4;
  localparam int DIG_W = $clog2(DIGITS);
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [DIGITS-1:0] ANODE_OFF = '1;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: one BCD nibble to an active-low {g,f,e,d,c,b,a} pattern; non-BCD values show a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  assign o_seg = (i_bcd > 4'd9) ? SEG_DASH : SEG_DIGIT[i_bcd];
endmodule

// File: rtl/seg7_channel_scanner.sv
// seg7_channel_scanner: picks one BCD channel (auto rotate or manual step) and multiplexes it onto a 4-digit display.
module seg7_channel_scanner
  import display_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DWELL_CYCLES = 200000000,
  parameter int DP_DIGIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16*N_CH-1:0] channels,
  input  logic              auto_mode,
  input  logic              btn_next,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [3:0]        ch_idx
);
  localparam int SW = $clog2(N_CH);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DWELL_CYCLES);
  logic [PW-1:0] r_pre;
  logic [DIG_W-1:0] r_dig;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_sel, r_ch;
  logic [15:0] r_snap;
  logic [DIGITS-1:0] r_an;
  logic [6:0] r_seg;
  logic r_dp;
  logic [15:0] w_ch [N_CH];
  logic w_wrap, w_frame, w_adv;
  logic [DIG_W-1:0] w_dig_nxt;
  logic [15:0] w_snap_nxt;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_ch[k] = channels[16*k +: 16];
  end
  assign w_wrap = r_pre == PW'(REFRESH_DIV - 1);
  assign w_frame = w_wrap && r_dig == DIG_W'(DIGITS - 1);
  assign w_dig_nxt = r_dig + 1'b1;
  assign w_adv = btn_next || (auto_mode && r_dwell == DW'(DWELL_CYCLES - 1));
  // Digit 0 of a new frame must already come from the incoming snapshot.
  assign w_snap_nxt = w_frame ? w_ch[r_sel] : r_snap;
  assign w_nib = w_snap_nxt[{w_dig_nxt, 2'b00} +: 4];
  bcd_to_seg7 u_dec (
    .i_bcd(w_nib),
    .o_seg(w_seg)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pre <= '0;
      r_dig <= DIG_W'(DIGITS - 1);
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_dig <= w_dig_nxt;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sel <= '0;
      r_dwell <= '0;
    end else begin
      if (w_adv) r_sel <= (r_sel == SW'(N_CH - 1)) ? '0 : r_sel + 1'b1;
      r_dwell <= (!auto_mode || w_adv) ? '0 : r_dwell + 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_snap <= '0;
      r_ch <= '0;
    end else if (w_frame) begin
      r_snap <= w_snap_nxt;
      r_ch <= r_sel;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_an <= ANODE_OFF;
      r_seg <= SEG_BLANK;
      r_dp <= 1'b1;
    end else if (w_wrap) begin
      r_an <= ~(DIGITS'(1) << w_dig_nxt);
      r_seg <= w_seg;
      r_dp <= w_dig_nxt != DIG_W'(DP_DIGIT);
    end
  assign an = r_an;
  assign seg = r_seg;
  assign dp = r_dp;
  assign ch_idx = 4'(r_ch);
endmodule

// File: tb/tb_seg7_channel_scanner.sv
// tb_seg7_channel_scanner: randomized scenarios checked against a time-based model of the display stage.
module tb_seg7_channel_scanner;
  localparam int N = 4, R = 4, D = 64;
  localparam logic [6:0] PAT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clk = 0, rst = 0, auto_mode = 0, btn_next = 0;
  logic [63:0] channels = '0;
  logic [3:0] an, ch_idx;
  logic [6:0] seg;
  logic dp;
  int checks = 0, errors = 0;
  int m_t, m_sel, m_run, m_ch;
  logic [15:0] m_snap;
  seg7_channel_scanner #(.N_CH(N), .REFRESH_DIV(R), .DWELL_CYCLES(D), .DP_DIGIT(3)) dut (
    .clk(clk), .rst(rst), .channels(channels), .auto_mode(auto_mode), .btn_next(btn_next),
    .an(an), .seg(seg), .dp(dp), .ch_idx(ch_idx)
  );
  always #5 clk = ~clk;
  // m_t counts edges since reset release; the lit digit and frame boundaries follow from it directly.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_t = 0; m_sel = 0; m_run = 0; m_ch = 0; m_snap = '0;
    end else begin : step
      int e;
      bit adv;
      e = m_t + 1;
      if (e % R == 0 && (e / R) % 4 == 1) begin
        m_snap = channels[16*m_sel +: 16];
        m_ch = m_sel;
      end
      adv = btn_next || (auto_mode && m_run == D - 1);
      m_sel = (m_sel + int'(adv)) % N;
      m_run = (!auto_mode || adv) ? 0 : m_run + 1;
      m_t = e;
    end
  function automatic int exp_dig();
    return (m_t / R + 3) % 4;
  endfunction
  function automatic logic [15:0] exp_all();
    logic [3:0] v;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    v = 4'((m_snap >> (4 * exp_dig())) & 16'hF);
    e_an = (m_t < R) ? 4'hF : ~(4'b0001 << exp_dig());
    e_seg = (m_t < R) ? 7'h7F : (v > 9) ? 7'h3F : PAT[v];
    return {e_an, e_seg, !(m_t >= R && exp_dig() == 3), m_ch[3:0]};
  endfunction
  task automatic test_reset();
    rst = 0;
    channels[15:0] = 16'h1234;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, seg, dp, ch_idx} !== 16'hFFF0) begin errors++; $display("FAIL reset_state got=%h exp=fff0", {an, seg, dp, ch_idx}); end
    rst = 1;
    repeat (R) @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001) begin errors++; $display("FAIL first_digit got an=%b seg=%b exp an=1110 seg=0011001", an, seg); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL reset_scan t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
    end
  endtask
  task automatic test_manual();
    int n;
    @(negedge clk);
    channels[31:16] = 16'h0999;
    btn_next = 1;
    @(negedge clk);
    btn_next = 0;
    n = 0;
    while (ch_idx !== 4'd1 && n < 4 * R + 2) begin @(negedge clk); n++; end
    checks++;
    if (ch_idx !== 4'd1) begin errors++; $display("FAIL manual_step got=%0d exp=1", ch_idx); end
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL manual_show t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
    end
    for (int k = 0; k < 4; k++) begin
      btn_next = 1;
      @(negedge clk);
      btn_next = 0;
      repeat (4 * R + 1) @(negedge clk);
      checks++;
      if (ch_idx !== 4'((2 + k) % 4) || ch_idx !== m_ch[3:0]) begin errors++; $display("FAIL manual_wrap got=%0d exp=%0d", ch_idx, (2 + k) % 4); end
    end
  endtask
  task automatic test_auto();
    logic [3:0] prev, held;
    int changes;
    channels = {$urandom, $urandom};
    auto_mode = 1;
    prev = ch_idx;
    changes = 0;
    for (int i = 0; i < 5 * D; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL auto_scan t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
      if (ch_idx !== prev) begin
        checks++;
        changes++;
        if (ch_idx !== 4'((prev + 1) % 4)) begin errors++; $display("FAIL auto_seq got=%0d exp=%0d", ch_idx, (prev + 1) % 4); end
        prev = ch_idx;
      end
    end
    checks++;
    if (changes < 4) begin errors++; $display("FAIL auto_count got=%0d exp>=4", changes); end
    auto_mode = 0;
    repeat (4 * R + 1) @(negedge clk);
    held = ch_idx;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if (ch_idx !== held || ch_idx !== m_ch[3:0]) begin errors++; $display("FAIL manual_hold got=%0d exp=%0d", ch_idx, held); end
    end
  endtask
  task automatic test_back_to_back();
    int n, s;
    auto_mode = 1;
    n = 0;
    while (m_run != D - 1 && n < 2 * D) begin @(negedge clk); n++; end
    checks++;
    if (m_run != D - 1 || dut.r_dwell !== 6'(D - 1)) begin errors++; $display("FAIL dwell_reach got=%0d exp=%0d", dut.r_dwell, D - 1); end
    s = m_sel;
    btn_next = 1;
    @(negedge clk);
    btn_next = 0;
    auto_mode = 0;
    checks++;
    if (dut.r_sel !== 2'((s + 1) % N) || dut.r_dwell !== 6'd0) begin errors++; $display("FAIL simul_adv got sel=%0d dwell=%0d exp sel=%0d dwell=0", dut.r_sel, dut.r_dwell, (s + 1) % N); end
    repeat (4 * R + 1) @(negedge clk);
    checks++;
    if (ch_idx !== 4'((s + 1) % N)) begin errors++; $display("FAIL simul_show got=%0d exp=%0d", ch_idx, (s + 1) % N); end
  endtask
  task automatic test_snapshot();
    @(negedge clk);
    rst = 0;
    channels[15:0] = 16'h1234;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (m_t == 6) channels[15:0] = 16'h12F4;
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL snap_scan t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
      if (m_t == 9 || m_t == 25) begin
        checks++;
        if (an !== 4'b1101 || seg !== (m_t == 9 ? 7'b0110000 : 7'b0111111)) begin errors++; $display("FAIL snap_digit t=%0d got an=%b seg=%b", m_t, an, seg); end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 32 == 0) auto_mode = 1'($urandom);
      btn_next = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) channels[16*$urandom_range(0, 3) +: 16] = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
    end
    btn_next = 0;
    auto_mode = 0;
  endtask
  task automatic test_async_reset();
    btn_next = 1;
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({an, seg, dp} !== 12'hFFF) begin errors++; $display("FAIL async_blank got an=%b seg=%b dp=%b", an, seg, dp); end
    @(negedge clk);
    btn_next = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (ch_idx !== 4'd0 || an !== 4'hF || dut.r_sel !== 2'd0) begin errors++; $display("FAIL async_release got ch=%0d an=%b sel=%0d", ch_idx, an, dut.r_sel); end
    repeat (4 * R) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, ch_idx} !== exp_all()) begin errors++; $display("FAIL async_scan t=%0d got=%h exp=%h", m_t, {an, seg, dp, ch_idx}, exp_all()); end
    end
  endtask
  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_back_to_back();
    test_snapshot();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_channel_scanner.md
# seg7_channel_scanner

Downstream display stage for the ADC front end. Takes the packed 16-bit BCD readings (four digits per channel) produced by the ADC/scaler/bin2bcd chain. Selects one channel at a time, either by automatic rotation or by a manual step pulse. Time-multiplexes the selected reading onto the Basys3 4-digit common-anode 7-segment display, using a per-frame snapshot so digits never tear mid-scan.

## Interface
- N_CH, 4: number of BCD channels on `channels`; legal range 2..16.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be ≥ 2.
- DWELL_CYCLES, 200000000: clk cycles per channel in auto mode; must be ≥ 4*REFRESH_DIV.
- DP_DIGIT, 3: digit position whose decimal point is lit (readings shown as x.xxx V).
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-low reset.
- channels  in  16*N_CH  packed BCD. Channel k occupies [16k+15:16k]. Within a channel, [3:0] is the least-significant digit.
- auto_mode  in  1  1 = rotate channels every DWELL_CYCLES; 0 = hold the current channel.
- btn_next  in  1  single-cycle pulse (already debounced upstream); advances the channel by one.
- an  out  4  digit anodes, active-low; an[0] = rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- ch_idx  out  4  channel currently being displayed (snapshot source).

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1. When it wraps, the digit index `dig` (0..3) increments mod 4.
- Frame start is the cycle where `pre` wraps and `dig` goes 3→0.
  - At frame start, `snap` ← channels[16*sel +: 16].
  - At frame start, ch_idx ← sel.
- Channel select `sel` (0..N_CH-1) advances by one, wrapping N_CH-1→0, when either:
  - btn_next = 1, or
  - auto_mode = 1 and the dwell counter reaches DWELL_CYCLES-1.
- The dwell counter restarts at 0 on any advance and whenever auto_mode = 0.
- If btn_next and dwell expiry occur in the same cycle, `sel` advances exactly once.
- Digit decode, via the bcd_to_seg7 sub-module:
  - 0..9 map to the standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - Nibble values 10..15 show a dash, 7'b0111111.
- an = ~(4'b0001 << dig).
- dp = 0 only when dig == DP_DIGIT; otherwise 1.
- Changes to `channels` between frame starts are ignored until the next frame start.

## Timing
- Reset (rst=0, asynchronous):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - ch_idx=0, sel=0, pre=0, dig=3, snap=0, dwell=0.
- The first frame start occurs REFRESH_DIV cycles after rst deasserts. an becomes 4'b1110 on the next edge after that frame start.
- an, seg and dp are registered and change together, exactly one cycle after the `pre` wrap that selects the digit. There are no glitches between digits.
- A channel advance updates `sel` on the next edge. That channel reaches ch_idx and the display at the next frame start: latency ≤ 4*REFRESH_DIV cycles.
- Asserting rst mid-frame blanks all outputs immediately and discards any pending advance.
- btn_next held high for M cycles advances M times. Generating a single pulse is the upstream's responsibility.

## Structure
- Shared package `display_pkg`:
  - Segment pattern constants SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK.
  - ANODE_OFF constant.
  - The digits-per-display constant (4).
- Sub-module `bcd_to_seg7`: purely combinational, 4-bit BCD in, 7-bit active-low pattern out. It is instantiated once, after the `snap` digit mux.
- Top: three counters (pre, dig, dwell), the sel/ch_idx logic, the snapshot register and the output registers.

## Test plan
- Bench parameters for all tests: N_CH=4, REFRESH_DIV=4, DWELL_CYCLES=64.
- Reset release, channels[15:0]=16'h1234, auto_mode=0:
  - After 4 cycles, an cycles 1110, 1101, 1011, 0111 with 4 cycles each.
  - seg shows 4, 3, 2, 1.
  - dp=0 only while an=0111.
- Manual step: btn_next pulsed once with channels[31:16]=16'h0999:
  - ch_idx goes 0→1 at the next frame start.
  - The display shows 0.999.
  - 4 further pulses wrap ch_idx 1→2→3→0→1.
- Auto mode on, no button:
  - sel advances every 64 cycles and ch_idx follows at frame starts, sequencing 0,1,2,3,0.
  - With auto_mode=0 the channel holds for ≥ 500 cycles.
- Simultaneous events: btn_next asserted in the exact cycle the dwell counter expires → sel advances by exactly 1 and the dwell counter restarts at 0.
- Snapshot and invalid digits: change channels[15:0] from 16'h1234 to 16'h12F4 mid-frame.
  - The current frame still shows 1234.
  - The next frame shows 1,2,dash,4, with an=1101 showing 7'b0111111.
- Async reset mid-frame: drive rst=0 between clock edges → an=1111, seg=7'b1111111 and dp=1 immediately (no clock edge needed); ch_idx=0 after release.
